// File: rtl/overlay_cfg_sched.sv
// Frame-synchronous configuration scheduler: two requesters share a round-robin
// write port into a shadow bank, which is copied to the live outputs at frame start.
module overlay_cfg_sched #(
  parameter logic [7:0] DEF_SQ_LEN = 8'd50,
  parameter logic [1:0] DEF_SPEED  = 2'd1,
  parameter logic [9:0] DEF_LUMA   = 10'h3FC,
  parameter logic [9:0] DEF_CB     = 10'h0B0,
  parameter logic [9:0] DEF_CR     = 10'h21F
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        cen_i,
  input  logic [3:0]  fvht_i,
  input  logic        lock_i,
  input  logic        a_req_i,
  input  logic [2:0]  a_addr_i,
  input  logic [9:0]  a_data_i,
  output logic        a_ack_o,
  input  logic        b_req_i,
  input  logic [2:0]  b_addr_i,
  input  logic [9:0]  b_data_i,
  output logic        b_ack_o,
  output logic        err_o,
  output logic        dirty_o,
  output logic        commit_o,
  output logic [7:0]  sq_len_1_o,
  output logic [7:0]  sq_len_2_o,
  output logic [1:0]  speed_1_o,
  output logic [1:0]  speed_2_o,
  output logic        vid_sel_o,
  output logic [29:0] colour_1_o
);

  typedef enum logic {IDLE, ACK} state_t;

  state_t      state, state_nxt;
  logic        last_b, last_b_nxt;
  logic        win_b, win_b_nxt;
  logic        win_err, win_err_nxt;
  logic        grant;
  logic [2:0]  g_addr;
  logic [9:0]  g_data;
  logic        wr_en;

  logic        v_d;
  logic        dirty;
  logic        commit_q;
  logic        frame_edge;
  logic        do_commit;

  logic [7:0]  sh_len_1, sh_len_2;
  logic [1:0]  sh_spd_1, sh_spd_2;
  logic        sh_sel;
  logic [9:0]  sh_luma, sh_cb;

  logic [7:0]  lv_len_1, lv_len_2;
  logic [1:0]  lv_spd_1, lv_spd_2;
  logic        lv_sel;
  logic [9:0]  lv_luma, lv_cb;

  logic        unused_fvht;
  assign unused_fvht = ^{fvht_i[3], fvht_i[1:0]};

  // Arbiter: on a simultaneous request the side not granted last time wins.
  always_comb begin
    state_nxt   = state;
    last_b_nxt  = last_b;
    win_b_nxt   = win_b;
    win_err_nxt = win_err;
    grant       = 1'b0;
    g_addr      = 3'd0;
    g_data      = 10'd0;
    case (state)
      IDLE: begin
        if (a_req_i || b_req_i) begin
          grant       = 1'b1;
          win_b_nxt   = (a_req_i && b_req_i) ? ~last_b : b_req_i;
          last_b_nxt  = win_b_nxt;
          g_addr      = win_b_nxt ? b_addr_i : a_addr_i;
          g_data      = win_b_nxt ? b_data_i : a_data_i;
          win_err_nxt = (g_addr == 3'd7);
          state_nxt   = ACK;
        end
      end
      ACK: state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  assign wr_en      = cen_i & grant & (g_addr != 3'd7);
  assign frame_edge = cen_i & fvht_i[2] & ~v_d;
  assign do_commit  = frame_edge & dirty & ~lock_i;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state    <= IDLE;
      last_b   <= 1'b1;
      win_b    <= 1'b0;
      win_err  <= 1'b0;
      v_d      <= 1'b0;
      dirty    <= 1'b0;
      commit_q <= 1'b0;
    end else if (cen_i) begin
      state    <= state_nxt;
      last_b   <= last_b_nxt;
      win_b    <= win_b_nxt;
      win_err  <= win_err_nxt;
      v_d      <= fvht_i[2];
      commit_q <= do_commit;
      // A write on the commit edge keeps dirty set so it lands next frame.
      if (wr_en)
        dirty <= 1'b1;
      else if (do_commit)
        dirty <= 1'b0;
    end
  end

  // Zero lengths and speeds are meaningless to the renderer, so they map to defaults.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      sh_len_1 <= DEF_SQ_LEN;
      sh_len_2 <= DEF_SQ_LEN;
      sh_spd_1 <= DEF_SPEED;
      sh_spd_2 <= DEF_SPEED;
      sh_sel   <= 1'b0;
      sh_luma  <= DEF_LUMA;
      sh_cb    <= DEF_CB;
    end else if (wr_en) begin
      case (g_addr)
        3'd0: sh_len_1 <= (g_data[7:0] == 8'd0) ? DEF_SQ_LEN : g_data[7:0];
        3'd1: sh_len_2 <= (g_data[7:0] == 8'd0) ? DEF_SQ_LEN : g_data[7:0];
        3'd2: sh_spd_1 <= (g_data[1:0] == 2'd0) ? DEF_SPEED : g_data[1:0];
        3'd3: sh_spd_2 <= (g_data[1:0] == 2'd0) ? DEF_SPEED : g_data[1:0];
        3'd4: sh_sel   <= g_data[0];
        3'd5: sh_luma  <= g_data;
        3'd6: sh_cb    <= g_data;
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      lv_len_1 <= DEF_SQ_LEN;
      lv_len_2 <= DEF_SQ_LEN;
      lv_spd_1 <= DEF_SPEED;
      lv_spd_2 <= DEF_SPEED;
      lv_sel   <= 1'b0;
      lv_luma  <= DEF_LUMA;
      lv_cb    <= DEF_CB;
    end else if (do_commit) begin
      lv_len_1 <= sh_len_1;
      lv_len_2 <= sh_len_2;
      lv_spd_1 <= sh_spd_1;
      lv_spd_2 <= sh_spd_2;
      lv_sel   <= sh_sel;
      lv_luma  <= sh_luma;
      lv_cb    <= sh_cb;
    end
  end

  assign a_ack_o    = (state == ACK) & ~win_b;
  assign b_ack_o    = (state == ACK) & win_b;
  assign err_o      = (state == ACK) & win_err;
  assign dirty_o    = dirty;
  assign commit_o   = commit_q;
  assign sq_len_1_o = lv_len_1;
  assign sq_len_2_o = lv_len_2;
  assign speed_1_o  = lv_spd_1;
  assign speed_2_o  = lv_spd_2;
  assign vid_sel_o  = lv_sel;
  assign colour_1_o = {lv_luma, lv_cb, DEF_CR};

endmodule

// File: tb/tb_overlay_cfg_sched.sv
// Bench for overlay_cfg_sched: reset values, a directed vector table, corner-case
// sequences, then random traffic against a register-map reference model.
module tb_overlay_cfg_sched;

  logic        clk = 1'b0;
  logic        rst;
  logic        cen;
  logic [3:0]  fvht;
  logic        lock;
  logic        a_req, b_req;
  logic [2:0]  a_addr, b_addr;
  logic [9:0]  a_data, b_data;
  logic        a_ack, b_ack, err, dirty, commit, vid_sel;
  logic [7:0]  sq_len_1, sq_len_2;
  logic [1:0]  speed_1, speed_2;
  logic [29:0] colour_1;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  overlay_cfg_sched dut (
    .clk_i(clk), .rst_i(rst), .cen_i(cen), .fvht_i(fvht), .lock_i(lock),
    .a_req_i(a_req), .a_addr_i(a_addr), .a_data_i(a_data), .a_ack_o(a_ack),
    .b_req_i(b_req), .b_addr_i(b_addr), .b_data_i(b_data), .b_ack_o(b_ack),
    .err_o(err), .dirty_o(dirty), .commit_o(commit),
    .sq_len_1_o(sq_len_1), .sq_len_2_o(sq_len_2),
    .speed_1_o(speed_1), .speed_2_o(speed_2),
    .vid_sel_o(vid_sel), .colour_1_o(colour_1)
  );

  // Reference model: registers held as an address-indexed array.
  int m_shadow[7];
  int m_live[7];
  int defaults[7] = '{50, 50, 1, 1, 0, 'h3FC, 'h0B0};
  bit m_dirty, m_commit, m_vd, m_busy, m_win_b, m_err, m_last_b;

  typedef struct {
    bit         cen, v, lock, a_req;
    logic [2:0] a_addr;
    logic [9:0] a_data;
    bit         b_req;
    logic [2:0] b_addr;
    logic [9:0] b_data;
    bit         e_a_ack, e_b_ack, e_err, e_dirty, e_commit;
    logic [7:0] e_sq1;
    logic [1:0] e_spd1;
  } vec_t;

  vec_t vecs[17];

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int fieldValue(input int addr, input int data);
    int v;
    case (addr)
      0, 1: begin v = data & 255; if (v == 0) v = 50; end
      2, 3: begin v = data & 3;   if (v == 0) v = 1;  end
      4:    v = data & 1;
      default: v = data & 1023;
    endcase
    return v;
  endfunction

  task automatic modelReset();
    m_shadow = defaults;
    m_live   = defaults;
    m_dirty = 0; m_commit = 0; m_vd = 0; m_busy = 0;
    m_win_b = 0; m_err = 0; m_last_b = 1;
  endtask

  task automatic modelStep();
    bit edge_now, do_commit, wrote, pick_b;
    int addr, data;
    if (!cen) return;
    edge_now  = fvht[2] && !m_vd;
    do_commit = edge_now && m_dirty && !lock;
    if (do_commit) m_live = m_shadow;
    wrote = 0;
    if (m_busy) m_busy = 0;
    else if (a_req || b_req) begin
      pick_b   = (a_req && b_req) ? !m_last_b : b_req;
      m_last_b = pick_b;
      m_win_b  = pick_b;
      addr     = pick_b ? int'(b_addr) : int'(a_addr);
      data     = pick_b ? int'(b_data) : int'(a_data);
      m_err    = (addr == 7);
      if (addr != 7) begin
        m_shadow[addr] = fieldValue(addr, data);
        wrote = 1;
      end
      m_busy = 1;
    end
    if (wrote) m_dirty = 1;
    else if (do_commit) m_dirty = 0;
    m_commit = do_commit;
    m_vd     = fvht[2];
  endtask

  task automatic clearInputs();
    cen = 1; fvht = 4'b0000; lock = 0;
    a_req = 0; a_addr = 0; a_data = 0;
    b_req = 0; b_addr = 0; b_data = 0;
  endtask

  // One clock: model consumes the current inputs, DUT clocks, return at the negedge.
  task automatic tick();
    modelStep();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic doReset();
    rst = 1;
    clearInputs();
    repeat (2) @(negedge clk);
    modelReset();
    rst = 0;
  endtask

  task automatic applyStimulus(input vec_t v);
    cen = v.cen; fvht = {1'b0, v.v, 2'b00}; lock = v.lock;
    a_req = v.a_req; a_addr = v.a_addr; a_data = v.a_data;
    b_req = v.b_req; b_addr = v.b_addr; b_data = v.b_data;
  endtask

  task automatic checkModel();
    logic [29:0] ec;
    ec = {10'(m_live[5]), 10'(m_live[6]), 10'h21F};
    checkOutput("rnd a_ack",  a_ack,  m_busy && !m_win_b);
    checkOutput("rnd b_ack",  b_ack,  m_busy && m_win_b);
    checkOutput("rnd err",    err,    m_busy && m_err);
    checkOutput("rnd dirty",  dirty,  m_dirty);
    checkOutput("rnd commit", commit, m_commit);
    checkOutput("rnd sq1",    sq_len_1, m_live[0]);
    checkOutput("rnd sq2",    sq_len_2, m_live[1]);
    checkOutput("rnd spd1",   speed_1,  m_live[2]);
    checkOutput("rnd spd2",   speed_2,  m_live[3]);
    checkOutput("rnd sel",    vid_sel,  m_live[4]);
    checkOutput("rnd colour", colour_1, ec);
  endtask

  initial begin
    rst = 1;
    clearInputs();
    modelReset();
    @(negedge clk);
    #1;
    checkOutput("reset sq1", sq_len_1, 50);
    checkOutput("reset sq2", sq_len_2, 50);
    checkOutput("reset spd1", speed_1, 1);
    checkOutput("reset spd2", speed_2, 1);
    checkOutput("reset sel", vid_sel, 0);
    checkOutput("reset colour", colour_1, {10'h3FC, 10'h0B0, 10'h21F});
    checkOutput("reset acks", {a_ack, b_ack, err}, 0);
    checkOutput("reset dirty/commit", {dirty, commit}, 0);

    // Directed table: write, commit, speed zero-substitution, addr 7, cen stalls.
    vecs[0]  = '{1,0,0, 1,3'd0,10'h380, 0,3'd0,10'h000, 1,0,0,1,0, 8'd50, 2'd1};
    vecs[1]  = '{1,0,0, 0,3'd0,10'h000, 0,3'd0,10'h000, 0,0,0,1,0, 8'd50, 2'd1};
    vecs[2]  = '{1,1,0, 0,3'd0,10'h000, 0,3'd0,10'h000, 0,0,0,0,1, 8'h80, 2'd1};
    vecs[3]  = '{1,1,0, 0,3'd0,10'h000, 0,3'd0,10'h000, 0,0,0,0,0, 8'h80, 2'd1};
    vecs[4]  = '{1,0,0, 0,3'd0,10'h000, 0,3'd0,10'h000, 0,0,0,0,0, 8'h80, 2'd1};
    vecs[5]  = '{1,0,0, 0,3'd0,10'h000, 1,3'd2,10'h006, 0,1,0,1,0, 8'h80, 2'd1};
    vecs[6]  = '{1,0,0, 0,3'd0,10'h000, 0,3'd0,10'h000, 0,0,0,1,0, 8'h80, 2'd1};
    vecs[7]  = '{1,1,0, 0,3'd0,10'h000, 0,3'd0,10'h000, 0,0,0,0,1, 8'h80, 2'd2};
    vecs[8]  = '{1,1,0, 0,3'd0,10'h000, 1,3'd7,10'h155, 0,1,1,0,0, 8'h80, 2'd2};
    vecs[9]  = '{1,0,0, 0,3'd0,10'h000, 0,3'd0,10'h000, 0,0,0,0,0, 8'h80, 2'd2};
    vecs[10] = '{0,0,0, 0,3'd0,10'h000, 1,3'd2,10'h000, 0,0,0,0,0, 8'h80, 2'd2};
    vecs[11] = '{1,0,0, 0,3'd0,10'h000, 1,3'd2,10'h000, 0,1,0,1,0, 8'h80, 2'd2};
    vecs[12] = '{0,0,0, 0,3'd0,10'h000, 0,3'd0,10'h000, 0,1,0,1,0, 8'h80, 2'd2};
    vecs[13] = '{1,0,0, 0,3'd0,10'h000, 0,3'd0,10'h000, 0,0,0,1,0, 8'h80, 2'd2};
    vecs[14] = '{1,1,0, 0,3'd0,10'h000, 0,3'd0,10'h000, 0,0,0,0,1, 8'h80, 2'd1};
    vecs[15] = '{0,1,0, 0,3'd0,10'h000, 0,3'd0,10'h000, 0,0,0,0,1, 8'h80, 2'd1};
    vecs[16] = '{1,0,0, 0,3'd0,10'h000, 0,3'd0,10'h000, 0,0,0,0,0, 8'h80, 2'd1};

    doReset();
    for (int i = 0; i < 17; i++) begin
      applyStimulus(vecs[i]);
      tick();
      checkOutput($sformatf("vec%0d a_ack", i),  a_ack,    vecs[i].e_a_ack);
      checkOutput($sformatf("vec%0d b_ack", i),  b_ack,    vecs[i].e_b_ack);
      checkOutput($sformatf("vec%0d err", i),    err,      vecs[i].e_err);
      checkOutput($sformatf("vec%0d dirty", i),  dirty,    vecs[i].e_dirty);
      checkOutput($sformatf("vec%0d commit", i), commit,   vecs[i].e_commit);
      checkOutput($sformatf("vec%0d sq1", i),    sq_len_1, vecs[i].e_sq1);
      checkOutput($sformatf("vec%0d spd1", i),   speed_1,  vecs[i].e_spd1);
    end

    // Round-robin: first contention goes to A, second to B.
    doReset();
    a_req = 1; a_addr = 3'd1; a_data = 10'h020;
    b_req = 1; b_addr = 3'd3; b_data = 10'h002;
    tick();
    checkOutput("rr1 acks", {a_ack, b_ack}, 2'b10);
    a_req = 0;
    tick();
    checkOutput("rr1 drop", {a_ack, b_ack}, 2'b00);
    a_req = 1; a_addr = 3'd0; a_data = 10'h040;
    tick();
    checkOutput("rr2 acks", {a_ack, b_ack}, 2'b01);
    b_req = 0;
    tick();
    checkOutput("rr2 drop", {a_ack, b_ack}, 2'b00);
    tick();
    checkOutput("rr3 acks", {a_ack, b_ack}, 2'b10);
    a_req = 0;
    tick();
    checkOutput("rr3 drop", {a_ack, b_ack}, 2'b00);

    // Lock holds off commits across two frame edges.
    doReset();
    a_req = 1; a_addr = 3'd1; a_data = 10'h033;
    tick();
    a_req = 0;
    tick();
    lock = 1; fvht[2] = 1;
    tick();
    checkOutput("lock1 commit", commit, 0);
    checkOutput("lock1 dirty", dirty, 1);
    checkOutput("lock1 sq2", sq_len_2, 50);
    fvht[2] = 0; tick();
    fvht[2] = 1; tick();
    checkOutput("lock2 commit", commit, 0);
    checkOutput("lock2 dirty", dirty, 1);
    lock = 0; fvht[2] = 0; tick();
    fvht[2] = 1; tick();
    checkOutput("unlock commit", commit, 1);
    checkOutput("unlock sq2", sq_len_2, 8'h33);
    checkOutput("unlock dirty", dirty, 0);

    // Write granted on the frame-edge cycle commits the old shadow value.
    doReset();
    a_req = 1; a_addr = 3'd0; a_data = 10'h011;
    tick();
    a_req = 0;
    tick();
    fvht[2] = 1; a_req = 1; a_addr = 3'd0; a_data = 10'h022;
    tick();
    checkOutput("edgewr commit", commit, 1);
    checkOutput("edgewr sq1", sq_len_1, 8'h11);
    checkOutput("edgewr ack", a_ack, 1);
    checkOutput("edgewr dirty", dirty, 1);
    a_req = 0;
    tick();
    checkOutput("edgewr hold", sq_len_1, 8'h11);
    fvht[2] = 0; tick();
    fvht[2] = 1; tick();
    checkOutput("edgewr next commit", commit, 1);
    checkOutput("edgewr next sq1", sq_len_1, 8'h22);
    checkOutput("edgewr next dirty", dirty, 0);

    // Reset while an ack is pending loses the transaction.
    doReset();
    b_req = 1; b_addr = 3'd4; b_data = 10'h001;
    tick();
    checkOutput("rstack pre", b_ack, 1);
    rst = 1;
    #1;
    checkOutput("rstack ack", b_ack, 0);
    checkOutput("rstack dirty", dirty, 0);
    checkOutput("rstack sq1", sq_len_1, 50);
    b_req = 0;
    @(negedge clk);
    modelReset();
    rst = 0;
    fvht[2] = 1;
    tick();
    checkOutput("rstack after ack", b_ack, 0);
    checkOutput("rstack after sel", vid_sel, 0);
    checkOutput("rstack no commit", commit, 0);

    // Random traffic with protocol-respecting requesters.
    doReset();
    for (int c = 0; c < 800; c++) begin
      cen  = ($urandom_range(4) != 0);
      lock = ($urandom_range(3) == 0);
      fvht[3] = 1'($urandom); fvht[1:0] = 2'($urandom);
      if ($urandom_range(7) == 0) fvht[2] = ~fvht[2];
      tick();
      checkModel();
      if (a_req) begin
        if (m_busy && !m_win_b) a_req = 0;
      end else if ($urandom_range(2) == 0) begin
        a_req = 1; a_addr = 3'($urandom_range(7)); a_data = 10'($urandom);
      end
      if (b_req) begin
        if (m_busy && m_win_b) b_req = 0;
      end else if ($urandom_range(2) == 0) begin
        b_req = 1; b_addr = 3'($urandom_range(7)); b_data = 10'($urandom);
      end
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
